// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by the multi-cycle controller and its condition evaluator.
package cpu_isa_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_CMP   = 4'b0011;
    localparam logic [3:0] OP_MEMX  = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_MOVIU = 4'b0111;
    localparam logic [3:0] OP_MOVI  = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0001;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_MOV   = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1100;
    localparam logic [3:0] COND_LT = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;

    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_C = 0;

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: 4-bit condition code against PSR flags.
// Purely combinational; undefined codes never take.
module cond_eval
    import cpu_isa_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       taken
);

    logic n, z, f, l, c;

    assign n = psr[PSR_N];
    assign z = psr[PSR_Z];
    assign f = psr[PSR_F];
    assign l = psr[PSR_L];
    assign c = psr[PSR_C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_HI: taken = l;
            COND_LS: taken = !l;
            COND_GT: taken = n;
            COND_LE: taken = !n;
            COND_FS: taken = f;
            COND_FC: taken = !f;
            COND_GE: taken = n | z;
            COND_LT: taken = !(n | z);
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller_mc.sv
// Multi-cycle FETCH/EXEC/MEM control unit; the state register is the only storage.
// Outputs decode combinationally from state, INS, PSR and MemReady; MemReady stalls FETCH and MEM.
module cpu_controller_mc
    import cpu_isa_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int PCIMM_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [15:0]        INS,
    input  logic [4:0]         PSR,
    input  logic               MemReady,
    output logic [3:0]         OpCode,
    output logic [3:0]         OpExt,
    output logic               RegWrite,
    output logic [REG_W-1:0]   RegIn,
    output logic [REG_W-1:0]   RegA,
    output logic [REG_W-1:0]   RegB,
    output logic [DATA_W-1:0]  Immediate,
    output logic [PCIMM_W-1:0] PCImmediate,
    output logic [1:0]         SelALU,
    output logic               SelMEM,
    output logic               MemRW,
    output logic               PCWrite,
    output logic               PCIncrement,
    output logic               PCReset,
    output logic               IRReset,
    output logic               IRWrite,
    output logic               PSRReset,
    output logic               IllegalIns
);

    localparam logic [PCIMM_W-1:0] PC_STEP = PCIMM_W'(1);
    localparam logic [1:0] SEL_IMM = 2'b00;
    localparam logic [1:0] SEL_REG = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    state_t state, state_nxt;

    logic [3:0]         op, ext, cond;
    logic               taken;
    logic [DATA_W-1:0]  imm_sext, imm_zext, imm_high;

    assign op  = INS[15:12];
    assign ext = INS[11:8];

    // Jcond carries its condition in the low byte, Bcond in the ext nibble.
    assign cond = (op == OP_MEMX) ? INS[7:4] : INS[11:8];

    assign imm_sext = DATA_W'($signed(INS[11:4]));
    assign imm_zext = DATA_W'(INS[11:4]);
    assign imm_high = {INS[11:4], {(DATA_W-8){1'b0}}};

    cond_eval u_cond_eval (
        .cond  (cond),
        .psr   (PSR),
        .taken (taken)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        OpCode      = '0;
        OpExt       = '0;
        RegWrite    = 1'b0;
        RegIn       = '0;
        RegA        = '0;
        RegB        = '0;
        Immediate   = '0;
        PCImmediate = '0;
        SelALU      = SEL_IMM;
        SelMEM      = 1'b0;
        MemRW       = 1'b0;
        PCWrite     = 1'b0;
        PCIncrement = 1'b0;
        PCReset     = 1'b0;
        IRReset     = 1'b0;
        IRWrite     = 1'b0;
        PSRReset    = 1'b0;
        IllegalIns  = 1'b0;
        state_nxt   = state;

        // Everything, including the active-low resets, is forced low while Reset is held.
        if (Reset) begin
            PCReset  = 1'b1;
            IRReset  = 1'b1;
            PSRReset = 1'b1;

            case (state)
                FETCH: begin
                    SelMEM    = 1'b1;
                    IRWrite   = MemReady;
                    state_nxt = MemReady ? EXEC : FETCH;
                end

                EXEC: begin
                    state_nxt = FETCH;
                    case (op)
                        OP_RTYPE, OP_CMP: begin
                            OpCode      = op;
                            OpExt       = ext;
                            RegA        = REG_W'(INS[7:4]);
                            RegB        = REG_W'(INS[3:0]);
                            SelALU      = SEL_REG;
                            RegIn       = (op == OP_RTYPE) ? REG_W'(INS[3:0]) : '0;
                            RegWrite    = (op == OP_RTYPE);
                            PCIncrement = 1'b1;
                            PCImmediate = PC_STEP;
                        end
                        OP_ADDI, OP_SUBI, OP_ADDUI, OP_MOVI, OP_MOVIU: begin
                            if (op == OP_MOVIU)
                                Immediate = imm_high;
                            else if (op == OP_ADDUI || op == OP_MOVI)
                                Immediate = imm_zext;
                            else
                                Immediate = imm_sext;
                            RegB        = REG_W'(INS[3:0]);
                            RegIn       = REG_W'(INS[3:0]);
                            RegWrite    = 1'b1;
                            PCIncrement = 1'b1;
                            PCImmediate = PC_STEP;
                        end
                        OP_CMPI: begin
                            Immediate   = imm_sext;
                            RegB        = REG_W'(INS[3:0]);
                            PCIncrement = 1'b1;
                            PCImmediate = PC_STEP;
                        end
                        OP_MEMX: begin
                            case (ext)
                                EXT_LOAD, EXT_STOR: state_nxt = MEM;
                                EXT_JCOND: begin
                                    RegA = REG_W'(INS[3:0]);
                                    if (taken) begin
                                        PCWrite = 1'b1;
                                    end else begin
                                        PCIncrement = 1'b1;
                                        PCImmediate = PC_STEP;
                                    end
                                end
                                default: begin
                                    IllegalIns  = 1'b1;
                                    PCIncrement = 1'b1;
                                    PCImmediate = PC_STEP;
                                end
                            endcase
                        end
                        OP_BCOND: begin
                            PCIncrement = 1'b1;
                            PCImmediate = taken ? PCIMM_W'($signed(INS[7:0])) : PC_STEP;
                        end
                        default: begin
                            IllegalIns  = 1'b1;
                            PCIncrement = 1'b1;
                            PCImmediate = PC_STEP;
                        end
                    endcase
                end

                MEM: begin
                    SelMEM = 1'b1;
                    RegB   = REG_W'(INS[7:4]);
                    OpCode = OP_RTYPE;
                    OpExt  = EXT_MOV;
                    if (ext == EXT_LOAD) begin
                        SelALU   = SEL_MEM;
                        RegIn    = REG_W'(INS[3:0]);
                        RegWrite = MemReady;
                    end else if (ext == EXT_STOR) begin
                        RegA  = REG_W'(INS[3:0]);
                        MemRW = 1'b1;
                    end
                    if (MemReady) begin
                        PCIncrement = 1'b1;
                        PCImmediate = PC_STEP;
                        state_nxt   = FETCH;
                    end
                end

                default: state_nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller_mc.sv
// Directed vector table, multi-cycle MEM/reset sequences and randomized run against a flag/ISA model.
module tb_cpu_controller_mc;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  opext;
        logic        regwrite;
        logic [3:0]  regin;
        logic [3:0]  rega;
        logic [3:0]  regb;
        logic [15:0] imm;
        logic [7:0]  pcimm;
        logic [1:0]  selalu;
        logic        selmem;
        logic        memrw;
        logic        pcwrite;
        logic        pcinc;
        logic        pcreset;
        logic        irreset;
        logic        irwrite;
        logic        psrreset;
        logic        illegal;
    } outs_t;

    typedef struct {
        logic [15:0] ins;
        logic [4:0]  psr;
        outs_t       exp;
    } vec_t;

    logic        Clock, Reset, MemReady;
    logic [15:0] INS;
    logic [4:0]  PSR;
    logic [3:0]  OpCode, OpExt;
    logic        RegWrite;
    logic [3:0]  RegIn, RegA, RegB;
    logic [15:0] Immediate;
    logic [7:0]  PCImmediate;
    logic [1:0]  SelALU;
    logic        SelMEM, MemRW, PCWrite, PCIncrement, PCReset, IRReset, IRWrite, PSRReset, IllegalIns;

    int tests = 0;
    int fails = 0;

    cpu_controller_mc #(.DATA_W(16), .REG_W(4), .PCIMM_W(8)) dut (
        .Clock(Clock), .Reset(Reset), .INS(INS), .PSR(PSR), .MemReady(MemReady),
        .OpCode(OpCode), .OpExt(OpExt), .RegWrite(RegWrite), .RegIn(RegIn),
        .RegA(RegA), .RegB(RegB), .Immediate(Immediate), .PCImmediate(PCImmediate),
        .SelALU(SelALU), .SelMEM(SelMEM), .MemRW(MemRW), .PCWrite(PCWrite),
        .PCIncrement(PCIncrement), .PCReset(PCReset), .IRReset(IRReset),
        .IRWrite(IRWrite), .PSRReset(PSRReset), .IllegalIns(IllegalIns)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic outs_t cap();
        outs_t o;
        o.opcode = OpCode;   o.opext = OpExt;    o.regwrite = RegWrite;
        o.regin = RegIn;     o.rega = RegA;      o.regb = RegB;
        o.imm = Immediate;   o.pcimm = PCImmediate; o.selalu = SelALU;
        o.selmem = SelMEM;   o.memrw = MemRW;    o.pcwrite = PCWrite;
        o.pcinc = PCIncrement; o.pcreset = PCReset; o.irreset = IRReset;
        o.irwrite = IRWrite; o.psrreset = PSRReset; o.illegal = IllegalIns;
        return o;
    endfunction

    function automatic outs_t base();
        outs_t o = '0;
        o.pcreset = 1'b1; o.irreset = 1'b1; o.psrreset = 1'b1;
        return o;
    endfunction

    function automatic outs_t step1(input outs_t i);
        outs_t o = i;
        o.pcinc = 1'b1; o.pcimm = 8'h01;
        return o;
    endfunction

    // Condition truth table indexed by cond code: bit k is the result for cond k.
    function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] p);
        bit n, z, f, l, cy;
        bit [15:0] t;
        n = p[4]; z = p[3]; f = p[2]; l = p[1]; cy = p[0];
        t = {1'b0, 1'b1, !(n | z), n | z, 2'b00, !f, f, !n, n, !l, l, !cy, cy, !z, z};
        return t[c];
    endfunction

    // st: 0 fetch, 1 execute, 2 memory phase.
    function automatic void model(input int st, input logic [15:0] ins, input logic [4:0] psr,
                                  input bit mr, output outs_t o, output int nst);
        logic [3:0]  hi, x;
        logic [15:0] sext8;
        hi = ins[15:12]; x = ins[11:8];
        sext8 = {{8{ins[11]}}, ins[11:4]};
        o = base(); nst = st;
        if (st == 0) begin
            o.selmem = 1'b1; o.irwrite = mr; nst = mr ? 1 : 0;
        end else if (st == 1) begin
            nst = 0;
            if (hi == 4'h0 || hi == 4'h3) begin
                o.opcode = hi; o.opext = x; o.rega = ins[7:4]; o.regb = ins[3:0];
                o.selalu = 2'b01;
                if (hi == 4'h0) begin o.regin = ins[3:0]; o.regwrite = 1'b1; end
                o = step1(o);
            end else if (hi >= 4'h5 && hi <= 4'h9) begin
                o.imm = (hi == 4'h7) ? {ins[11:4], 8'h00} :
                        (hi == 4'h6 || hi == 4'h8) ? {8'h00, ins[11:4]} : sext8;
                o.regb = ins[3:0]; o.regin = ins[3:0]; o.regwrite = 1'b1;
                o = step1(o);
            end else if (hi == 4'hB) begin
                o.imm = sext8; o.regb = ins[3:0];
                o = step1(o);
            end else if (hi == 4'h4 && (x == 4'h0 || x == 4'h1)) begin
                nst = 2;
            end else if (hi == 4'h4 && x == 4'hC) begin
                o.rega = ins[3:0];
                if (cond_ok(ins[7:4], psr)) o.pcwrite = 1'b1;
                else o = step1(o);
            end else if (hi == 4'hC) begin
                o.pcinc = 1'b1;
                o.pcimm = cond_ok(x, psr) ? ins[7:0] : 8'h01;
            end else begin
                o.illegal = 1'b1;
                o = step1(o);
            end
        end else begin
            o.selmem = 1'b1; o.regb = ins[7:4]; o.opext = 4'hD;
            if (x == 4'h0) begin o.selalu = 2'b10; o.regin = ins[3:0]; o.regwrite = mr; end
            if (x == 4'h1) begin o.rega = ins[3:0]; o.memrw = 1'b1; end
            if (mr) begin o = step1(o); nst = 0; end
        end
    endfunction

    task automatic chk(input string name, input outs_t act, input outs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] ins, input logic [4:0] psr, input logic mr,
                       input outs_t exp, input string name);
        @(negedge Clock);
        INS = ins; PSR = psr; MemReady = mr;
        #2;
        chk(name, cap(), exp);
    endtask

    function automatic logic [15:0] rand_ins();
        logic [3:0] ops [12];
        logic [3:0] xs [4];
        logic [15:0] r;
        ops = '{4'h0, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'h4, 4'h4, 4'hC, 4'h2};
        xs  = '{4'h0, 4'h1, 4'hC, 4'h7};
        r = 16'($urandom);
        if ($urandom_range(0, 7) != 0) r[15:12] = ops[$urandom_range(0, 11)];
        if (r[15:12] == 4'h4) r[11:8] = xs[$urandom_range(0, 3)];
        return r;
    endfunction

    vec_t  tbl[$];
    outs_t e, fetch_exp, got;
    int    st, nst;

    task automatic add(input logic [15:0] ins, input logic [4:0] psr, input outs_t exp);
        vec_t v;
        v.ins = ins; v.psr = psr; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        Reset = 1'b0; MemReady = 1'b1; INS = '0; PSR = '0;

        fetch_exp = base(); fetch_exp.selmem = 1'b1; fetch_exp.irwrite = 1'b1;

        e = base(); e.opext = 4'h5; e.rega = 4'd1; e.regb = 4'd2; e.regin = 4'd2;
        e.regwrite = 1'b1; e.selalu = 2'b01; add(16'h0512, 5'h00, step1(e));
        e = base(); e.opcode = 4'h3; e.opext = 4'h5; e.rega = 4'd1; e.regb = 4'd2;
        e.selalu = 2'b01; add(16'h3512, 5'h1F, step1(e));
        e = base(); e.imm = 16'hFFFF; e.regb = 4'd3; e.regin = 4'd3; e.regwrite = 1'b1;
        add(16'h5FF3, 5'h00, step1(e));
        e.imm = 16'h00FF; add(16'h6FF3, 5'h00, step1(e));
        e.imm = 16'hAB00; add(16'h7AB3, 5'h00, step1(e));
        e.imm = 16'h0080; add(16'h8803, 5'h00, step1(e));
        e.imm = 16'hFF80; add(16'h9803, 5'h00, step1(e));
        e = base(); e.imm = 16'h007F; e.regb = 4'd2; add(16'hB7F2, 5'h00, step1(e));
        e = base(); e.pcinc = 1'b1; e.pcimm = 8'hFE; add(16'hC0FE, 5'b01000, e);
        e = base(); add(16'hC0FE, 5'b10111, step1(e));
        e = base(); e.pcwrite = 1'b1; e.rega = 4'd5; add(16'h4CE5, 5'h00, e);
        e = base(); e.rega = 4'd5; add(16'h4C05, 5'h00, step1(e));
        e = base(); e.illegal = 1'b1; add(16'h2000, 5'h00, step1(e));

        repeat (3) cyc(16'h0512, 5'h00, 1'b1, outs_t'('0), "reset_all_zero");

        @(negedge Clock);
        Reset = 1'b1; INS = tbl[0].ins; PSR = tbl[0].psr; MemReady = 1'b1;
        #2;
        chk("release_fetch", cap(), fetch_exp);

        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) cyc(tbl[i].ins, tbl[i].psr, 1'b1, fetch_exp, "tbl_fetch");
            cyc(tbl[i].ins, tbl[i].psr, 1'b1, tbl[i].exp, $sformatf("tbl_exec_%04h", tbl[i].ins));
        end

        // Illegal pulse must be gone on the following fetch; this fetch also loads the LOAD.
        cyc(16'h4034, 5'h00, 1'b1, fetch_exp, "illegal_one_cycle");
        cyc(16'h4034, 5'h00, 1'b0, base(), "load_exec");
        e = base(); e.selmem = 1'b1; e.regb = 4'd3; e.opext = 4'hD; e.selalu = 2'b10; e.regin = 4'd4;
        cyc(16'h4034, 5'h00, 1'b0, e, "load_wait1");
        cyc(16'h4034, 5'h00, 1'b0, e, "load_wait2");
        e.regwrite = 1'b1;
        cyc(16'h4034, 5'h00, 1'b1, step1(e), "load_done");

        cyc(16'h4134, 5'h00, 1'b1, fetch_exp, "load_back_to_fetch");
        cyc(16'h4134, 5'h00, 1'b0, base(), "stor_exec");
        e = base(); e.selmem = 1'b1; e.regb = 4'd3; e.rega = 4'd4; e.opext = 4'hD; e.memrw = 1'b1;
        cyc(16'h4134, 5'h00, 1'b0, e, "stor_wait");
        #1 Reset = 1'b0;
        #1 chk("stor_abort", cap(), outs_t'('0));
        @(negedge Clock);
        Reset = 1'b1; MemReady = 1'b0;
        #2;
        e = base(); e.selmem = 1'b1;
        chk("abort_fetch_hold", cap(), e);

        st = 0;
        for (int n = 0; n < 800; n++) begin
            @(negedge Clock);
            if (st == 0) INS = rand_ins();
            PSR = 5'($urandom);
            MemReady = ($urandom_range(0, 3) != 0);
            #2;
            model(st, INS, PSR, MemReady, e, nst);
            got = cap();
            chk($sformatf("rand_%0d_st%0d_%04h", n, st, INS), got, e);
            st = nst;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
